// File: rtl/comb_pipe_pkg.sv
// Shared types, constants and the reference transform for the comb-pipe checker.
package comb_pipe_pkg;

    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned IN_W     = 2;
    localparam int unsigned DATA_W   = 4;

    localparam int unsigned ADD_C = 1;
    localparam int unsigned MUL_0 = 2;
    localparam int unsigned MUL_1 = 3;
    localparam int unsigned MUL_2 = 2;

    // Pipe contents right after reset, entry 0 appears at edge 1.
    localparam logic [PIPE_LAT-1:0][DATA_W-1:0] PRIME_TAB = {4'd0, 4'd12, 4'd6, 4'd1};

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_CHECK = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] exp_val;
        logic [DATA_W-1:0] got_val;
    } capture_t;

    // Each stage truncates to DATA_W bits, mirroring the checked pipe.
    function automatic logic [DATA_W-1:0] f_ref(input logic [IN_W-1:0] x);
        logic [DATA_W-1:0] s;
        s = DATA_W'(x) + DATA_W'(ADD_C);
        s = s * DATA_W'(MUL_0);
        s = s * DATA_W'(MUL_1);
        s = s * DATA_W'(MUL_2);
        return s;
    endfunction

endpackage

// File: rtl/comb_pipe_chk_if.sv
// Stimulus/observation bundle between the checked pipe environment and the checker.
interface comb_pipe_chk_if #(
    parameter int unsigned CNT_W = 8
);
    import comb_pipe_pkg::*;

    logic [IN_W-1:0]   ina;
    logic [DATA_W-1:0] dut_out;
    logic              chk_en;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              err;
    logic [DATA_W-1:0] first_exp;
    logic [DATA_W-1:0] first_got;
    logic              halted;

    modport master (
        output ina, dut_out, chk_en,
        input  match_cnt, err_cnt, err, first_exp, first_got, halted
    );

    modport slave (
        input  ina, dut_out, chk_en,
        output match_cnt, err_cnt, err, first_exp, first_got, halted
    );

endinterface

// File: rtl/comb_pipe_dly.sv
// Fixed-depth shift register holding the recent ina history.
module comb_pipe_dly #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/comb_pipe_chk.sv
// Lock-step checker for the 4-stage comb pipe: primes, compares, counts, halts on error limit.
module comb_pipe_chk
    import comb_pipe_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ERR_LIMIT = 8
) (
    input logic            clk,
    input logic            rst_n,
    comb_pipe_chk_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(PIPE_LAT);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  errc_q, errc_d;
    capture_t          cap_q, cap_d;
    logic              halted_q;
    logic [IN_W-1:0]   ina_dly;
    logic [DATA_W-1:0] exp_c;
    logic              cmp_en_c;
    logic              hit_c;
    logic              lim_hit_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    comb_pipe_dly #(
        .DEPTH (PIPE_LAT),
        .WIDTH (IN_W)
    ) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.ina),
        .dout (ina_dly)
    );

    assign exp_c    = (state_q == ST_PRIME) ? PRIME_TAB[idx_q] : f_ref(ina_dly);
    assign cmp_en_c = bus.chk_en && (state_q != ST_HALT);
    assign hit_c    = (bus.dut_out == exp_c);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PRIME;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: priming advances regardless of chk_en; error limit wins over everything
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_PRIME: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(PIPE_LAT - 1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_CHECK;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_PRIME;
        endcase
        if ((state_q != ST_HALT) && lim_hit_c) begin
            state_d = ST_HALT;
        end
    end

    // Output/datapath next values
    always_comb begin
        match_d = match_q;
        errc_d  = errc_q;
        cap_d   = cap_q;
        if (cmp_en_c) begin
            if (hit_c) begin
                match_d = sat_inc(match_q);
            end else begin
                errc_d = sat_inc(errc_q);
                if (!cap_q.err) begin
                    cap_d.err     = 1'b1;
                    cap_d.exp_val = exp_c;
                    cap_d.got_val = bus.dut_out;
                end
            end
        end
        lim_hit_c = (ERR_LIMIT != 0) && (32'(errc_d) >= 32'(ERR_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q  <= '0;
            errc_q   <= '0;
            cap_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            match_q  <= match_d;
            errc_q   <= errc_d;
            cap_q    <= cap_d;
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign bus.match_cnt = match_q;
    assign bus.err_cnt   = errc_q;
    assign bus.err       = cap_q.err;
    assign bus.first_exp = cap_q.exp_val;
    assign bus.first_got = cap_q.got_val;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_comb_pipe_chk.sv
// Bench for comb_pipe_chk: directed scenarios plus random traffic against an edge-indexed model.
module tb_comb_pipe_chk;
    import comb_pipe_pkg::*;

    localparam int unsigned CW0  = 8;
    localparam int unsigned LIM0 = 8;
    localparam int unsigned CW1  = 3;
    localparam int unsigned LIM1 = 0;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic [1:0] ina_s    = '0;
    logic [3:0] dut_s    = '0;
    logic       chk_en_s = 1'b0;

    always #5 clk = ~clk;

    comb_pipe_chk_if #(.CNT_W(CW0)) bus0 ();
    comb_pipe_chk_if #(.CNT_W(CW1)) bus1 ();

    assign bus0.ina     = ina_s;
    assign bus0.dut_out = dut_s;
    assign bus0.chk_en  = chk_en_s;
    assign bus1.ina     = ina_s;
    assign bus1.dut_out = dut_s;
    assign bus1.chk_en  = chk_en_s;

    comb_pipe_chk #(.CNT_W(CW0), .ERR_LIMIT(LIM0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    comb_pipe_chk #(.CNT_W(CW1), .ERR_LIMIT(LIM1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk  = 0;
    int n_fail = 0;
    bit armed  = 0;

    // Reference behaviour in plain arithmetic
    function automatic int ref_f(input int x);
        return ((x + 1) * 12) % 16;
    endfunction

    function automatic int ref_prime(input int edge_no);
        case (edge_no)
            1:       return 1;
            2:       return 6;
            3:       return 12;
            default: return 0;
        endcase
    endfunction

    // Model: edges counted since reset release, full ina log indexed by edge
    int m_n;
    int m_hist[$];
    int m_match[2];
    int m_errc[2];
    int m_fe[2];
    int m_fg[2];
    bit m_err[2];
    bit m_halt[2];
    int cmax[2] = '{(1 << CW0) - 1, (1 << CW1) - 1};
    int lim[2]  = '{int'(LIM0), int'(LIM1)};

    initial begin
        int e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_n = 0;
                m_hist.delete();
                for (int i = 0; i < 2; i++) begin
                    m_match[i] = 0; m_errc[i] = 0; m_fe[i] = 0; m_fg[i] = 0;
                    m_err[i] = 0; m_halt[i] = 0;
                end
            end else begin
                m_n++;
                e = (m_n <= 4) ? ref_prime(m_n) : ref_f(m_hist[m_n-5]);
                for (int i = 0; i < 2; i++) begin
                    if (!m_halt[i] && chk_en_s) begin
                        if (int'(dut_s) == e) begin
                            if (m_match[i] < cmax[i]) m_match[i]++;
                        end else begin
                            if (m_errc[i] < cmax[i]) m_errc[i]++;
                            if (!m_err[i]) begin
                                m_err[i] = 1; m_fe[i] = e; m_fg[i] = int'(dut_s);
                            end
                        end
                        if (lim[i] != 0 && m_errc[i] >= lim[i]) m_halt[i] = 1;
                    end
                end
                m_hist.push_back(int'(ina_s));
            end
        end
    end

    task automatic cmp_inst(input int i, input int mc, input int ec, input bit er,
                            input int fe, input int fg, input bit h);
        n_chk++;
        if (mc != m_match[i] || ec != m_errc[i] || er != m_err[i] ||
            fe != m_fe[i] || fg != m_fg[i] || h != m_halt[i]) begin
            n_fail++;
            $display("FAIL cyc_dut%0d t=%0t got mc=%0d ec=%0d err=%0d fe=%0d fg=%0d h=%0d exp mc=%0d ec=%0d err=%0d fe=%0d fg=%0d h=%0d",
                     i, $time, mc, ec, er, fe, fg, h,
                     m_match[i], m_errc[i], m_err[i], m_fe[i], m_fg[i], m_halt[i]);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                cmp_inst(0, int'(bus0.match_cnt), int'(bus0.err_cnt), bus0.err,
                         int'(bus0.first_exp), int'(bus0.first_got), bus0.halted);
                cmp_inst(1, int'(bus1.match_cnt), int'(bus1.err_cnt), bus1.err,
                         int'(bus1.first_exp), int'(bus1.first_got), bus1.halted);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
        end
    endtask

    // Stimulus side: a correct pipe, optionally overridden on one edge
    int drv_n;
    int drv_hist[$];

    task automatic drive(input int a, input bit en, input bit force_en, input int fv);
        int k;
        int good;
        k    = drv_n + 1;
        good = (k <= 4) ? ref_prime(k) : ref_f(drv_hist[k-5]);
        ina_s    = 2'(a);
        chk_en_s = en;
        dut_s    = force_en ? 4'(fv) : 4'(good);
        @(posedge clk);
        #1;
        drv_hist.push_back(a & 3);
        drv_n = k;
    endtask

    task automatic do_reset(input bit check_zero);
        rst_n = 1'b0;
        armed = 1;
        drv_n = 0;
        drv_hist.delete();
        #1;
        if (check_zero) begin
            chk("rst_match", int'(bus0.match_cnt), 0);
            chk("rst_errc",  int'(bus0.err_cnt), 0);
            chk("rst_err",   int'(bus0.err), 0);
            chk("rst_fe",    int'(bus0.first_exp), 0);
            chk("rst_fg",    int'(bus0.first_got), 0);
            chk("rst_halt",  int'(bus0.halted), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset(1'b1);

        // Correct pipe, ina = edge mod 4
        for (int k = 1; k <= 20; k++) drive(k % 4, 1'b1, 1'b0, 0);
        chk("a_match", int'(bus0.match_cnt), 20);
        chk("a_errc",  int'(bus0.err_cnt), 0);
        chk("a_err",   int'(bus0.err), 0);
        chk("sat_match", int'(bus1.match_cnt), 7);

        // Single corruption at edge 9 where 8 is expected
        do_reset(1'b0);
        for (int k = 1; k <= 16; k++) drive(k % 4, 1'b1, k == 9, 5);
        chk("b_err",   int'(bus0.err), 1);
        chk("b_errc",  int'(bus0.err_cnt), 1);
        chk("b_fe",    int'(bus0.first_exp), 8);
        chk("b_fg",    int'(bus0.first_got), 5);
        chk("b_match", int'(bus0.match_cnt), 15);

        // Stuck output -> halt at error limit
        do_reset(1'b0);
        for (int k = 1; k <= 12; k++) begin
            drive(k % 4, 1'b1, 1'b1, 15);
            if (k == 7) chk("c_halt7", int'(bus0.halted), 0);
            if (k == 8) begin
                chk("c_halt8", int'(bus0.halted), 1);
                chk("c_errc8", int'(bus0.err_cnt), 8);
            end
        end
        chk("c_errc",  int'(bus0.err_cnt), 8);
        chk("c_match", int'(bus0.match_cnt), 0);
        chk("c_fe",    int'(bus0.first_exp), 1);
        chk("c_fg",    int'(bus0.first_got), 15);
        chk("c_halt",  int'(bus0.halted), 1);
        chk("c_sat_errc", int'(bus1.err_cnt), 7);
        chk("c_nohalt",   int'(bus1.halted), 0);

        // Reset out of HALT, prime restarts expecting 1
        do_reset(1'b1);
        drive(1, 1'b1, 1'b1, 1);
        chk("d_match", int'(bus0.match_cnt), 1);
        chk("d_err",   int'(bus0.err), 0);

        // Checking disabled during priming and beyond
        do_reset(1'b0);
        for (int k = 1; k <= 10; k++) drive(k % 4, k >= 7, 1'b0, 0);
        chk("e_match", int'(bus0.match_cnt), 4);
        chk("e_errc",  int'(bus0.err_cnt), 0);
        chk("e_err",   int'(bus0.err), 0);

        // Random traffic with sporadic corruption and resets
        for (int r = 0; r < 10; r++) begin
            int len;
            int bad_mod;
            do_reset(1'b0);
            len     = int'($urandom_range(40, 250));
            bad_mod = (r == 3) ? 3 : 16;
            for (int k = 0; k < len; k++) begin
                drive(int'($urandom_range(0, 3)), ($urandom % 4) != 0,
                      (int'($urandom) % bad_mod) == 0, int'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/comb_pipe_chk.md
COMB_PIPE_CHK -- requirements
Module: comb_pipe_chk

Interface
REQ-001 Parameter CNT_W, default 8: width of the match and error counters.
REQ-002 Parameter ERR_LIMIT, default 8: error count at which the checker halts; 0 disables halting.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, same clock as the checked pipe.
REQ-005 rst_n  input  1  asynchronous active-low reset, same reset event as the checked pipe.
REQ-006 ina  input  2  stimulus driven into the checked pipe, sampled on every edge.
REQ-007 dut_out  input  4  output of the checked pipe, sampled on every edge.
REQ-008 chk_en  input  1  when low, comparisons are skipped and counters hold; the history still shifts.
REQ-009 match_cnt  output  CNT_W  number of compared cycles that matched.
REQ-010 err_cnt  output  CNT_W  number of compared cycles that mismatched.
REQ-011 err  output  1  sticky flag, set on the first mismatch.
REQ-012 first_exp  output  4  expected value at the first mismatch.
REQ-013 first_got  output  4  dut_out value at the first mismatch.
REQ-014 halted  output  1  high in HALT state.

Function
REQ-015 Reference transform: f(x) = ((x+1)*2*3*2) mod 16, with every stage truncated to 4 bits; f(0..3) = 12, 8, 4, 0.
REQ-016 Pipe latency is 4 edges: dut_out sampled at edge k+4 shall equal f(ina sampled at edge k).
REQ-017 After reset release, the four prime values of the pipe are 1, 6, 12, 0, expected at edges 1, 2, 3 and 4 respectively.
REQ-018 States: PRIME, CHECK, HALT; reset enters PRIME with prime index 0.
REQ-019 PRIME: on each edge, compare dut_out against the prime table entry at the index, then increment the index; after index 3, go to CHECK.
REQ-020 CHECK: on each edge, compare dut_out against f(ina delayed 4 edges).
REQ-021 Each compare increments match_cnt or err_cnt by exactly 1, and only when chk_en=1 and the state is not HALT.
REQ-022 Both counters saturate at 2^CNT_W-1 and never wrap.
REQ-023 First mismatch: set err and load first_exp/first_got on the same edge as the err_cnt increment; both fields are frozen after that.
REQ-024 When ERR_LIMIT≠0 and err_cnt reaches ERR_LIMIT, the next state is HALT.
REQ-025 HALT is left only by reset; in HALT all counters and captures hold.
REQ-026 In PRIME with chk_en=0, the prime index still advances, so prime-to-CHECK timing is independent of chk_en.
REQ-027 An ina history younger than 4 edges is never compared; history slots are filled only by post-reset samples.
REQ-028 All outputs are registered; no output depends combinationally on any input.

Reset
REQ-029 On rst_n low: state=PRIME, index=0, match_cnt=0, err_cnt=0, err=0, first_exp=0, first_got=0, halted=0, history cleared to 0.
REQ-030 Reset asserted mid-CHECK or mid-HALT aborts immediately; the prime sequence restarts at edge 1 after release.

Structure
REQ-031 Package comb_pipe_pkg holds:
- the state enum;
- PIPE_LAT=4;
- the stage multipliers (2, 3, 2) and add constant 1;
- the prime table {1,6,12,0};
- the function f.
REQ-032 Sub-module comb_pipe_dly shall be a parameterised-depth 2-bit shift register with async active-low clear, instanced at depth PIPE_LAT.

Verification
REQ-033 Reset, then drive ina=0,1,2,3 repeatedly with chk_en=1 against a correct pipe for 20 edges -> match_cnt=20, err_cnt=0, err=0.
REQ-034 Correct pipe, then force dut_out=5 at edge 9 while expected is 8 -> err=1, err_cnt=1, first_exp=8, first_got=5; later matches still increment match_cnt.
REQ-035 Hold dut_out=15 from reset with ERR_LIMIT=8 -> halted=1 after edge 8, err_cnt=8, first_exp=1, first_got=15; counters static thereafter.
REQ-036 chk_en=0 for edges 1-6, then 1 for edges 7-10, correct pipe -> match_cnt=4 and compares from edge 7 use the correct 4-deep history.
REQ-037 CNT_W=3, 12 matching edges -> match_cnt saturates at 7.
REQ-038 Assert rst_n low for one cycle during HALT -> all outputs 0; the prime compare at the next edge 1 expects 1.
